branch_predictor: RTL and testbench

- Parametrised dynamic branch predictor for the pipelined core. It succeeds the single-cycle combinational branch decision logic.
- Fetch-stage lookup is combinational. It returns a predicted direction and target from a table of 2-bit saturating counters and a tagged branch target buffer (BTB).
- Execute-stage update trains the tables with the resolved outcome. It also flags mispredictions and keeps a misprediction counter.
- MODE selects bimodal indexing or gshare indexing (PC XOR global history).

---
 rtl/branch_predictor.sv | 124 ++++++++++++
 tb/tb_branch_predictor.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: 2-bit saturating counters plus a direct-mapped tagged BTB.
// Combinational fetch lookup; execute-stage training, misprediction flag and counter.
module branch_predictor #(
  parameter int XLEN  = 32,
  parameter int IDX_W = 6,
  parameter int GHR_W = 4,
  parameter int MODE  = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  fetchPC,
  output logic             predTaken,
  output logic [XLEN-1:0]  predTarget,
  input  logic             updValid,
  input  logic [XLEN-1:0]  updPC,
  input  logic             updTaken,
  input  logic [XLEN-1:0]  updTarget,
  input  logic             updJump,
  input  logic             updPredTaken,
  input  logic [XLEN-1:0]  updPredTarget,
  output logic             mispredict,
  output logic [CNT_W-1:0] mispredCount,
  output logic [GHR_W-1:0] ghr
);

  localparam int unsigned DEPTH = 2 ** IDX_W;
  localparam int          TAG_W = XLEN - IDX_W - 2;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_t;

  ctr_t             r_cnt   [DEPTH];
  logic             r_valid [DEPTH];
  logic [TAG_W-1:0] r_tag   [DEPTH];
  logic [XLEN-1:0]  r_tgt   [DEPTH];
  logic [GHR_W-1:0] r_ghr;
  logic             r_mispred;
  logic [CNT_W-1:0] r_count;

  logic [IDX_W-1:0] w_ghrExt;
  logic [IDX_W-1:0] w_fIdx;
  logic [IDX_W-1:0] w_fCIdx;
  logic [IDX_W-1:0] w_uIdx;
  logic [IDX_W-1:0] w_uCIdx;
  logic [1:0]       w_fCnt;
  logic             w_fHit;
  logic             w_mispred;
  ctr_t             w_uCnt;
  ctr_t             w_cntNext;
  logic             w_unused;

  assign w_ghrExt = IDX_W'(r_ghr);
  assign w_fIdx   = fetchPC[IDX_W+1:2];
  assign w_uIdx   = updPC[IDX_W+1:2];
  assign w_fCIdx  = (MODE == 1) ? (w_fIdx ^ w_ghrExt) : w_fIdx;
  assign w_uCIdx  = (MODE == 1) ? (w_uIdx ^ w_ghrExt) : w_uIdx;
  assign w_unused = ^{fetchPC[1:0], updPC[1:0]};

  // Lookup reads current state only, so a same-cycle update is seen after the edge.
  assign w_fCnt     = r_cnt[w_fCIdx];
  assign w_fHit     = r_valid[w_fIdx] && (r_tag[w_fIdx] == fetchPC[XLEN-1:IDX_W+2]);
  assign predTaken  = w_fHit && w_fCnt[1];
  assign predTarget = predTaken ? r_tgt[w_fIdx] : fetchPC + XLEN'(4);

  assign w_mispred = (updPredTaken != updTaken) ||
                     (updTaken && (updPredTarget != updTarget));

  assign w_uCnt = r_cnt[w_uCIdx];

  always_comb begin
    w_cntNext = w_uCnt;
    if (updJump) begin
      w_cntNext = STRONG_T;
    end else begin
      case (w_uCnt)
        STRONG_NT: w_cntNext = updTaken ? WEAK_NT  : STRONG_NT;
        WEAK_NT:   w_cntNext = updTaken ? WEAK_T   : STRONG_NT;
        WEAK_T:    w_cntNext = updTaken ? STRONG_T : WEAK_NT;
        STRONG_T:  w_cntNext = updTaken ? STRONG_T : WEAK_T;
        default:   w_cntNext = WEAK_NT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_cnt[IDX_W'(i)]   <= WEAK_NT;
        r_valid[IDX_W'(i)] <= 1'b0;
        r_tag[IDX_W'(i)]   <= '0;
        r_tgt[IDX_W'(i)]   <= '0;
      end
      r_ghr     <= '0;
      r_mispred <= 1'b0;
      r_count   <= '0;
    end else begin
      r_mispred <= updValid && w_mispred;
      if (updValid) begin
        r_cnt[w_uCIdx] <= w_cntNext;
        if (updTaken) begin
          r_valid[w_uIdx] <= 1'b1;
          r_tag[w_uIdx]   <= updPC[XLEN-1:IDX_W+2];
          r_tgt[w_uIdx]   <= updTarget;
        end
        if (!updJump) begin
          r_ghr <= GHR_W'({r_ghr, updTaken});
        end
        if (w_mispred && (r_count != '1)) begin
          r_count <= r_count + CNT_W'(1);
        end
      end
    end
  end

  assign mispredict   = r_mispred;
  assign mispredCount = r_count;
  assign ghr          = r_ghr;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: bimodal and gshare instances on shared stimulus,
// each checked against an array-based reference model of the prediction rules.
module tb_branch_predictor;

  localparam int XLEN  = 32;
  localparam int IDX_W = 6;
  localparam int GHR_W = 4;
  localparam int CNT_W = 16;
  localparam int DEPTH = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic [XLEN-1:0]  fetchPC;
  logic             updValid, updTaken, updJump, updPredTaken;
  logic [XLEN-1:0]  updPC, updTarget, updPredTarget;
  logic             p0T, p1T, mp0, mp1;
  logic [XLEN-1:0]  p0Tgt, p1Tgt;
  logic [CNT_W-1:0] mc0, mc1;
  logic [GHR_W-1:0] g0, g1;

  int checks = 0;
  int errors = 0;

  // Reference model state, one set per mode (0 = bimodal, 1 = gshare)
  int unsigned m_cnt [2][DEPTH];
  bit          m_val [2][DEPTH];
  int unsigned m_tag [2][DEPTH];
  logic [31:0] m_tgt [2][DEPTH];
  int unsigned m_ghr [2];
  bit          m_misp[2];
  int unsigned m_mc  [2];

  branch_predictor #(.XLEN(XLEN), .IDX_W(IDX_W), .GHR_W(GHR_W), .MODE(0), .CNT_W(CNT_W)) dut0 (
    .clk(clk), .reset(reset), .fetchPC(fetchPC), .predTaken(p0T), .predTarget(p0Tgt),
    .updValid(updValid), .updPC(updPC), .updTaken(updTaken), .updTarget(updTarget),
    .updJump(updJump), .updPredTaken(updPredTaken), .updPredTarget(updPredTarget),
    .mispredict(mp0), .mispredCount(mc0), .ghr(g0));

  branch_predictor #(.XLEN(XLEN), .IDX_W(IDX_W), .GHR_W(GHR_W), .MODE(1), .CNT_W(CNT_W)) dut1 (
    .clk(clk), .reset(reset), .fetchPC(fetchPC), .predTaken(p1T), .predTarget(p1Tgt),
    .updValid(updValid), .updPC(updPC), .updTaken(updTaken), .updTarget(updTarget),
    .updJump(updJump), .updPredTaken(updPredTaken), .updPredTarget(updPredTarget),
    .mispredict(mp1), .mispredCount(mc1), .ghr(g1));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_cnt[m][i] = 1; m_val[m][i] = 0; m_tag[m][i] = 0; m_tgt[m][i] = 0;
      end
      m_ghr[m] = 0; m_misp[m] = 0; m_mc[m] = 0;
    end
  endtask

  task automatic model_lookup(input int m, input logic [31:0] pc,
                              output bit t, output logic [31:0] tgt);
    int unsigned i, ci;
    bit hit;
    i   = (pc >> 2) % DEPTH;
    ci  = (m == 1) ? (i ^ m_ghr[m]) : i;
    hit = m_val[m][i] && (m_tag[m][i] == (pc >> (IDX_W + 2)));
    t   = hit && (m_cnt[m][ci] >= 2);
    tgt = t ? m_tgt[m][i] : pc + 32'd4;
  endtask

  task automatic model_update(input int m, input logic [31:0] pc, input bit tk,
                              input logic [31:0] tg, input bit jp, input bit pt,
                              input logic [31:0] ptg);
    int unsigned i, ci;
    bit mis;
    i  = (pc >> 2) % DEPTH;
    ci = (m == 1) ? (i ^ m_ghr[m]) : i;
    if (jp) m_cnt[m][ci] = 3;
    else if (tk) m_cnt[m][ci] = (m_cnt[m][ci] == 3) ? 3 : m_cnt[m][ci] + 1;
    else m_cnt[m][ci] = (m_cnt[m][ci] == 0) ? 0 : m_cnt[m][ci] - 1;
    if (tk) begin
      m_val[m][i] = 1; m_tag[m][i] = pc >> (IDX_W + 2); m_tgt[m][i] = tg;
    end
    if (!jp) m_ghr[m] = ((m_ghr[m] << 1) | tk) % (1 << GHR_W);
    mis = (pt != tk) || (tk && (ptg != tg));
    m_misp[m] = mis;
    if (mis && m_mc[m] < 65535) m_mc[m]++;
  endtask

  // Applies one update across a clock edge; called at posedge+1, returns at posedge+1.
  task automatic do_upd(input logic [31:0] pc, input bit tk, input logic [31:0] tg,
                        input bit jp, input bit pt, input logic [31:0] ptg);
    updValid = 1; updPC = pc; updTaken = tk; updTarget = tg; updJump = jp;
    updPredTaken = pt; updPredTarget = ptg;
    @(posedge clk);
    model_update(0, pc, tk, tg, jp, pt, ptg);
    model_update(1, pc, tk, tg, jp, pt, ptg);
    #1;
    updValid = 0;
  endtask

  task automatic test_reset();
    reset = 1; updValid = 0; updPC = '0; updTaken = 0; updTarget = '0; updJump = 0;
    updPredTaken = 0; updPredTarget = '0; fetchPC = 32'h100;
    repeat (2) @(posedge clk);
    #1; reset = 0; model_reset();
    #1;
    checks++; if (p0T !== 1'b0)        begin errors++; $display("FAIL reset_predTaken0 got %b exp 0", p0T); end
    checks++; if (p0Tgt !== 32'h104)   begin errors++; $display("FAIL reset_predTarget0 got %h exp 104", p0Tgt); end
    checks++; if (p1T !== 1'b0)        begin errors++; $display("FAIL reset_predTaken1 got %b exp 0", p1T); end
    checks++; if (g0 !== '0 || g1 !== '0) begin errors++; $display("FAIL reset_ghr got %h/%h exp 0", g0, g1); end
    checks++; if (mc0 !== '0 || mc1 !== '0) begin errors++; $display("FAIL reset_count got %0d/%0d exp 0", mc0, mc1); end
    checks++; if (mp0 !== 1'b0 || mp1 !== 1'b0) begin errors++; $display("FAIL reset_mispredict got %b/%b exp 0", mp0, mp1); end
  endtask

  task automatic test_train();
    bit t; logic [31:0] tg;
    do_upd(32'h100, 1, 32'h080, 0, 0, 32'h104);
    checks++; if (mp0 !== 1'b1) begin errors++; $display("FAIL train_mispredict got %b exp 1", mp0); end
    checks++; if (mc0 !== 16'd1) begin errors++; $display("FAIL train_count got %0d exp 1", mc0); end
    checks++; if (g0 !== 4'(m_ghr[0])) begin errors++; $display("FAIL train_ghr got %h exp %h", g0, m_ghr[0]); end
    fetchPC = 32'h100; #1;
    model_lookup(0, fetchPC, t, tg);
    checks++; if (p0T !== 1'b1 || p0T !== t) begin errors++; $display("FAIL train_predTaken got %b exp 1", p0T); end
    checks++; if (p0Tgt !== 32'h080 || p0Tgt !== tg) begin errors++; $display("FAIL train_predTarget got %h exp 080", p0Tgt); end
    @(posedge clk); m_misp[0] = 0; m_misp[1] = 0; #1;
    checks++; if (mp0 !== 1'b0) begin errors++; $display("FAIL train_mispredict_fall got %b exp 0", mp0); end
    checks++; if (mc0 !== 16'd1) begin errors++; $display("FAIL train_count_hold got %0d exp 1", mc0); end
  endtask

  task automatic test_saturation();
    bit t; logic [31:0] tg;
    for (int k = 0; k < 4; k++) do_upd(32'h100, 1, 32'h080, 0, 1, 32'h080);
    do_upd(32'h100, 0, 32'h080, 0, 1, 32'h080);
    fetchPC = 32'h100; #1;
    model_lookup(0, fetchPC, t, tg);
    checks++; if (p0T !== 1'b1 || p0T !== t) begin errors++; $display("FAIL sat_weak_taken got %b exp 1", p0T); end
    for (int k = 0; k < 3; k++) do_upd(32'h100, 0, 32'h080, 0, 1, 32'h080);
    #1;
    model_lookup(0, fetchPC, t, tg);
    checks++; if (p0T !== 1'b0 || p0T !== t) begin errors++; $display("FAIL sat_not_taken got %b exp 0", p0T); end
    checks++; if (p0Tgt !== 32'h104) begin errors++; $display("FAIL sat_fallthrough got %h exp 104", p0Tgt); end
    checks++; if (mc0 !== 16'(m_mc[0])) begin errors++; $display("FAIL sat_count got %0d exp %0d", mc0, m_mc[0]); end
  endtask

  task automatic test_jump();
    int unsigned g0pre, g1pre;
    bit t; logic [31:0] tg;
    g0pre = m_ghr[0]; g1pre = m_ghr[1];
    do_upd(32'h200, 1, 32'h400, 1, 0, 32'h204);
    checks++; if (g0 !== 4'(g0pre) || g1 !== 4'(g1pre)) begin errors++; $display("FAIL jump_ghr got %h/%h exp %h/%h", g0, g1, g0pre, g1pre); end
    fetchPC = 32'h200; #1;
    checks++; if (p0T !== 1'b1 || p0Tgt !== 32'h400) begin errors++; $display("FAIL jump_pred0 got %b %h exp 1 400", p0T, p0Tgt); end
    model_lookup(1, fetchPC, t, tg);
    checks++; if (p1T !== 1'b1 || p1T !== t || p1Tgt !== tg) begin errors++; $display("FAIL jump_pred1 got %b %h exp 1 %h", p1T, p1Tgt, tg); end
  endtask

  task automatic test_alias();
    bit t0, t1; logic [31:0] tg0, tg1;
    do_upd(32'h100, 1, 32'h300, 0, 0, 32'h104);
    do_upd(32'h100 + 4 * DEPTH, 1, 32'h500, 0, 0, 32'h204);
    fetchPC = 32'h100; #1;
    checks++; if (p0T !== 1'b0 || p0Tgt !== 32'h104) begin errors++; $display("FAIL alias_miss got %b %h exp 0 104", p0T, p0Tgt); end
    checks++; if (p1T !== 1'b0) begin errors++; $display("FAIL alias_miss1 got %b exp 0", p1T); end
    // same-cycle lookup and update of 0x100
    updValid = 1; updPC = 32'h100; updTaken = 1; updTarget = 32'h700; updJump = 0;
    updPredTaken = 0; updPredTarget = 32'h104;
    #1;
    checks++; if (p0T !== 1'b0 || p0Tgt !== 32'h104) begin errors++; $display("FAIL rbw_old got %b %h exp 0 104", p0T, p0Tgt); end
    @(posedge clk);
    model_update(0, 32'h100, 1, 32'h700, 0, 0, 32'h104);
    model_update(1, 32'h100, 1, 32'h700, 0, 0, 32'h104);
    #1; updValid = 0; #1;
    model_lookup(0, fetchPC, t0, tg0);
    model_lookup(1, fetchPC, t1, tg1);
    checks++; if (p0T !== 1'b1 || p0Tgt !== 32'h700 || p0T !== t0) begin errors++; $display("FAIL rbw_new got %b %h exp 1 700", p0T, p0Tgt); end
    checks++; if (p1T !== t1 || p1Tgt !== tg1) begin errors++; $display("FAIL rbw_new1 got %b %h exp %b %h", p1T, p1Tgt, t1, tg1); end
  endtask

  task automatic test_gshare_pattern();
    bit t, tk, t0; logic [31:0] tg, tg0;
    reset = 1; #2; reset = 0; model_reset();
    @(posedge clk); #1;
    fetchPC = 32'h340;
    for (int k = 0; k < 16; k++) begin
      tk = (k % 2 == 0);
      #1;
      model_lookup(1, fetchPC, t, tg);
      model_lookup(0, fetchPC, t0, tg0);
      checks++; if (p1T !== t || p1Tgt !== tg) begin errors++; $display("FAIL gshare_lookup it%0d got %b %h exp %b %h", k, p1T, p1Tgt, t, tg); end
      checks++; if (p0T !== t0 || p0Tgt !== tg0) begin errors++; $display("FAIL bimodal_lookup it%0d got %b %h exp %b %h", k, p0T, p0Tgt, t0, tg0); end
      do_upd(32'h340, tk, 32'h500, 0, t, tg);
      checks++; if (mp1 !== m_misp[1] || mc1 !== 16'(m_mc[1]) || g1 !== 4'(m_ghr[1])) begin
        errors++; $display("FAIL gshare_update it%0d got %b %0d %h exp %b %0d %h", k, mp1, mc1, g1, m_misp[1], m_mc[1], m_ghr[1]);
      end
      if (k >= 6) begin
        checks++; if (mp1 !== 1'b0) begin errors++; $display("FAIL gshare_warm it%0d mispredict got %b exp 0", k, mp1); end
      end
    end
  endtask

  task automatic test_async_reset();
    do_upd(32'h340, 1, 32'h500, 0, 0, 32'h344);
    updValid = 1; updPC = 32'h380; updTaken = 1; updTarget = 32'h900; updJump = 0;
    updPredTaken = 0; updPredTarget = 32'h384; fetchPC = 32'h380;
    #2; reset = 1; #1;
    checks++; if (mp0 !== 1'b0 || mp1 !== 1'b0) begin errors++; $display("FAIL areset_mispredict got %b/%b exp 0", mp0, mp1); end
    checks++; if (mc0 !== '0 || mc1 !== '0) begin errors++; $display("FAIL areset_count got %0d/%0d exp 0", mc0, mc1); end
    checks++; if (g0 !== '0 || g1 !== '0) begin errors++; $display("FAIL areset_ghr got %h/%h exp 0", g0, g1); end
    fetchPC = 32'h340; #1;
    checks++; if (p0T !== 1'b0 || p1T !== 1'b0 || p0Tgt !== 32'h344) begin errors++; $display("FAIL areset_lookup got %b %b %h exp 0 0 344", p0T, p1T, p0Tgt); end
    @(posedge clk); #1;
    reset = 0; updValid = 0; model_reset();
    fetchPC = 32'h380; #1;
    checks++; if (p0T !== 1'b0 || p1T !== 1'b0 || g0 !== '0) begin errors++; $display("FAIL areset_drop_update got %b %b %h exp 0 0 0", p0T, p1T, g0); end
  endtask

  task automatic test_back_to_back_random();
    bit t0, t1, tk, jp, pt; logic [31:0] tg0, tg1, pc, tgt, ptg;
    for (int k = 0; k < 300; k++) begin
      pc      = ($urandom_range(0, 7) << 2) | ($urandom_range(0, 1) << 8);
      fetchPC = ($urandom_range(0, 3) == 0) ? pc : (($urandom_range(0, 7) << 2) | ($urandom_range(0, 1) << 8));
      tk  = $urandom_range(0, 1);
      jp  = ($urandom_range(0, 5) == 0);
      if (jp) tk = 1;
      tgt = ($urandom_range(0, 3) << 4) | 32'h1000;
      model_lookup(0, pc, pt, ptg);
      if ($urandom_range(0, 3) == 0) begin pt = $urandom_range(0, 1); ptg = tgt; end
      updValid = ($urandom_range(0, 4) != 0);
      updPC = pc; updTaken = tk; updTarget = tgt; updJump = jp;
      updPredTaken = pt; updPredTarget = ptg;
      #1;
      model_lookup(0, fetchPC, t0, tg0);
      model_lookup(1, fetchPC, t1, tg1);
      checks++; if (p0T !== t0 || p0Tgt !== tg0) begin errors++; $display("FAIL rnd_lookup0 it%0d got %b %h exp %b %h", k, p0T, p0Tgt, t0, tg0); end
      checks++; if (p1T !== t1 || p1Tgt !== tg1) begin errors++; $display("FAIL rnd_lookup1 it%0d got %b %h exp %b %h", k, p1T, p1Tgt, t1, tg1); end
      @(posedge clk);
      if (updValid) begin
        model_update(0, pc, tk, tgt, jp, pt, ptg);
        model_update(1, pc, tk, tgt, jp, pt, ptg);
      end else begin
        m_misp[0] = 0; m_misp[1] = 0;
      end
      #1;
      checks++; if (mp0 !== m_misp[0] || mc0 !== 16'(m_mc[0]) || g0 !== 4'(m_ghr[0])) begin
        errors++; $display("FAIL rnd_state0 it%0d got %b %0d %h exp %b %0d %h", k, mp0, mc0, g0, m_misp[0], m_mc[0], m_ghr[0]);
      end
      checks++; if (mp1 !== m_misp[1] || mc1 !== 16'(m_mc[1]) || g1 !== 4'(m_ghr[1])) begin
        errors++; $display("FAIL rnd_state1 it%0d got %b %0d %h exp %b %0d %h", k, mp1, mc1, g1, m_misp[1], m_mc[1], m_ghr[1]);
      end
    end
    updValid = 0;
  endtask

  initial begin
    test_reset();
    test_train();
    test_saturation();
    test_jump();
    test_alias();
    test_gshare_pattern();
    test_async_reset();
    test_back_to_back_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
